// File: rtl/fp32_pkg.sv
// Shared IEEE 754 single-precision field definitions and stage bundles.
// Used by the float adder pipeline and the float multiplier.
package fp32_pkg;

   localparam int FP_EXP_W  = 8;
   localparam int FP_MANT_W = 23;
   localparam int FP_BIAS   = 127;
   localparam int FP_AL_W   = FP_MANT_W + 4;

   localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;
   localparam logic [31:0]         FP_NAN     = 32'h7FC00000;

   typedef struct packed {
      logic                 sign;
      logic [FP_EXP_W-1:0]  exp;
      logic [FP_MANT_W-1:0] mant;
   } fp32_t;

   // unpack/align -> add
   typedef struct packed {
      logic                 spec;
      logic [31:0]          spec_val;
      logic                 sign;
      logic                 sub;
      logic [FP_EXP_W-1:0]  exp;
      logic [FP_AL_W-1:0]   mx;
      logic [FP_AL_W-1:0]   my;
   } s1_t;

   // add -> normalize/pack
   typedef struct packed {
      logic                 spec;
      logic [31:0]          spec_val;
      logic                 sign;
      logic [FP_EXP_W-1:0]  exp;
      logic [FP_AL_W:0]     sum;
   } s2_t;

   function automatic logic fp_is_nan(fp32_t x);
      return (x.exp == FP_EXP_MAX) && (x.mant != '0);
   endfunction

   function automatic logic fp_is_inf(fp32_t x);
      return (x.exp == FP_EXP_MAX) && (x.mant == '0);
   endfunction

   function automatic logic fp_is_zero(fp32_t x);
      return x.exp == '0;
   endfunction

endpackage

// File: rtl/fp_lzc28.sv
// Combinational 28-bit leading-zero counter.
// Ports: x (28-bit value), count (leading zeros, 28 when x is zero).
module fp_lzc28 (
   input  logic [27:0] x,
   output logic [4:0]  count
);

   logic found;

   always_comb begin
      count = 5'd28;
      found = 1'b0;
      for (int i = 27; i >= 0; i--) begin
         if (!found && x[i]) begin
            count = 5'(27 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fadd_pipe.sv
// Pipelined fp32 adder/subtractor, truncating, subnormals flushed to zero.
// Ports: clk, rst (async high), in_valid/in_ready, a, b, op (1 = a-b),
//        in_tag, out_valid/out_ready, result, out_tag.
module fadd_pipe
   import fp32_pkg::*;
#(
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic             op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result,
   output logic [TAG_W-1:0] out_tag
);

   logic adv;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // operand capture; B sign already reflects op
   logic             v0;
   fp32_t            a_q;
   fp32_t            b_q;
   logic [TAG_W-1:0] t0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0  <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         t0  <= '0;
      end else if (adv) begin
         v0  <= in_valid;
         a_q <= a;
         b_q <= {b[31] ^ op, b[30:0]};
         t0  <= in_tag;
      end
   end

   // stage 1: unpack, specials, swap, align
   fp32_t      x;
   fp32_t      y;
   logic       swap;
   logic [7:0] d;
   s1_t        s1_d;
   logic       nan_a, nan_b, inf_a, inf_b;
   logic       zro_a, zro_b;

   always_comb begin
      nan_a = fp_is_nan(a_q);
      nan_b = fp_is_nan(b_q);
      inf_a = fp_is_inf(a_q);
      inf_b = fp_is_inf(b_q);
      zro_a = fp_is_zero(a_q);
      zro_b = fp_is_zero(b_q);

      swap = {b_q.exp, b_q.mant} > {a_q.exp, a_q.mant};
      x    = swap ? b_q : a_q;
      y    = swap ? a_q : b_q;
      d    = x.exp - y.exp;

      s1_d      = '0;
      s1_d.sign = x.sign;
      s1_d.sub  = x.sign ^ y.sign;
      s1_d.exp  = x.exp;
      s1_d.mx   = {1'b1, x.mant, 3'b000};
      // no sticky: bits shifted past the guard positions are lost
      s1_d.my   = (d >= 8'd27) ? '0 : ({1'b1, y.mant, 3'b000} >> d);

      s1_d.spec = 1'b1;
      if (nan_a || nan_b)
         s1_d.spec_val = FP_NAN;
      else if (inf_a && inf_b && (a_q.sign != b_q.sign))
         s1_d.spec_val = FP_NAN;
      else if (inf_a)
         s1_d.spec_val = a_q;
      else if (inf_b)
         s1_d.spec_val = b_q;
      else if (zro_a && zro_b)
         s1_d.spec_val = {a_q.sign & b_q.sign, 31'd0};
      else if (zro_a)
         s1_d.spec_val = b_q;
      else if (zro_b)
         s1_d.spec_val = a_q;
      else
         s1_d.spec = 1'b0;
   end

   logic             v1;
   s1_t              s1_q;
   logic [TAG_W-1:0] t1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1   <= 1'b0;
         s1_q <= '0;
         t1   <= '0;
      end else if (adv) begin
         v1   <= v0;
         s1_q <= s1_d;
         t1   <= t0;
      end
   end

   // stage 2: magnitude add/subtract; |X| >= |Y| keeps the difference positive
   s2_t s2_d;

   always_comb begin
      s2_d          = '0;
      s2_d.spec     = s1_q.spec;
      s2_d.spec_val = s1_q.spec_val;
      s2_d.sign     = s1_q.sign;
      s2_d.exp      = s1_q.exp;
      if (s1_q.sub)
         s2_d.sum = {1'b0, s1_q.mx} - {1'b0, s1_q.my};
      else
         s2_d.sum = {1'b0, s1_q.mx} + {1'b0, s1_q.my};
   end

   logic             v2;
   s2_t              s2_q;
   logic [TAG_W-1:0] t2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2   <= 1'b0;
         s2_q <= '0;
         t2   <= '0;
      end else if (adv) begin
         v2   <= v1;
         s2_q <= s2_d;
         t2   <= t1;
      end
   end

   // stage 3: normalize, range check, pack
   logic [4:0]        lz;
   logic [4:0]        sh;
   logic [27:0]       nsh;
   logic signed [9:0] e_n;
   logic [22:0]       m_n;
   logic [31:0]       res_d;

   fp_lzc28 u_lzc (
      .x     (s2_q.sum),
      .count (lz)
   );

   always_comb begin
      sh  = '0;
      nsh = '0;
      e_n = $signed({2'b00, s2_q.exp});
      m_n = '0;
      if (s2_q.sum[27]) begin
         e_n = e_n + 10'sd1;
         m_n = 23'(s2_q.sum >> 4);
      end else begin
         // hidden bit belongs at 26, one below the carry position
         sh  = lz - 5'd1;
         nsh = s2_q.sum << sh;
         e_n = e_n - $signed({5'b00000, sh});
         m_n = 23'(nsh >> 3);
      end

      if (s2_q.spec)
         res_d = s2_q.spec_val;
      else if (s2_q.sum == '0)
         res_d = '0;
      else if (e_n >= 10'sd255)
         res_d = {s2_q.sign, FP_EXP_MAX, 23'd0};
      else if (e_n <= 10'sd0)
         res_d = {s2_q.sign, 31'd0};
      else
         res_d = {s2_q.sign, e_n[7:0], m_n};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         out_tag   <= '0;
      end else if (adv) begin
         out_valid <= v2;
         result    <= res_d;
         out_tag   <= t2;
      end
   end

endmodule

// File: tb/tb_fadd_pipe.sv
// Scoreboard bench for fadd_pipe: directed cases, stall, reset, random.
// Expected results come from constants or an arithmetic reference model.
module tb_fadd_pipe;

   localparam int TAG_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      a;
   logic [31:0]      b;
   logic             op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      result;
   logic [TAG_W-1:0] out_tag;

   fadd_pipe #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   outs_seen = 0;
   logic rand_on = 1'b0;

   // value = (1.mant) * 2^(exp-127); work in units of 2^(exp_x-127-26)
   function automatic logic [31:0] ref_add(logic [31:0] fa,
                                           logic [31:0] fb,
                                           logic        fop);
      logic [31:0] bb, xv, yv, t;
      logic        sx, sy;
      int          ex, ey, d, e;
      longint      mx, my, r;
      bb = fb ^ {fop, 31'd0};
      if ((fa[30:23] == 8'hFF && fa[22:0] != 0) ||
          (bb[30:23] == 8'hFF && bb[22:0] != 0))
         return 32'h7FC00000;
      if (fa[30:0] == 31'h7F800000 && bb[30:0] == 31'h7F800000)
         return (fa[31] == bb[31]) ? fa : 32'h7FC00000;
      if (fa[30:0] == 31'h7F800000) return fa;
      if (bb[30:0] == 31'h7F800000) return bb;
      if (fa[30:23] == 0 && bb[30:23] == 0)
         return {fa[31] & bb[31], 31'd0};
      if (fa[30:23] == 0) return bb;
      if (bb[30:23] == 0) return fa;
      xv = fa;
      yv = bb;
      if (bb[30:0] > fa[30:0]) begin
         t  = xv;
         xv = yv;
         yv = t;
      end
      sx = xv[31];
      sy = yv[31];
      ex = int'(xv[30:23]);
      ey = int'(yv[30:23]);
      mx = (64'd8388608 + longint'(xv[22:0])) * 8;
      my = (64'd8388608 + longint'(yv[22:0])) * 8;
      d  = ex - ey;
      if (d >= 27) my = 0;
      else my = my / (64'd1 << d);
      r = (sx == sy) ? mx + my : mx - my;
      if (r == 0) return 32'h0;
      e = ex;
      while (r >= 64'd134217728) begin
         r = r / 2;
         e = e + 1;
      end
      while (r < 64'd67108864) begin
         r = r * 2;
         e = e - 1;
      end
      if (e >= 255) return {sx, 8'hFF, 23'd0};
      if (e <= 0) return {sx, 31'd0};
      return {sx, 8'(e), 23'((r / 8) % 64'd8388608)};
   endfunction

   function automatic logic [31:0] rnd_fp(int near);
      logic [31:0] sp[8];
      int          k, e;
      sp = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000,
             32'h7FC00000, 32'h7F800001, 32'h00000123, 32'h7F7FFFFF};
      k = int'($urandom_range(0, 19));
      if (k == 0) return sp[$urandom_range(0, 7)];
      if (k < 12) e = near + int'($urandom_range(0, 8)) - 4;
      else e = int'($urandom_range(1, 254));
      if (e < 1) e = 1;
      if (e > 254) e = 254;
      return {1'($urandom), 8'(e), 23'($urandom)};
   endfunction

   // output side: every transfer pops one expectation in order
   always @(negedge clk) begin
      exp_t ex;
      if (!rst && out_valid && out_ready) begin
         checks++;
         outs_seen++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out got=%h tag=%h", result, out_tag);
         end else begin
            ex = sb_q.pop_front();
            if (result !== ex.res || out_tag !== ex.tag) begin
               failures++;
               $display("FAIL sb_result got=%h/%h want=%h/%h",
                        result, out_tag, ex.res, ex.tag);
            end
         end
      end
   end

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // call at posedge+1; returns at posedge+1 just after acceptance
   task automatic send(logic [31:0] sa, logic [31:0] sbv, logic sop,
                       logic [TAG_W-1:0] tg, logic use_w, logic [31:0] w);
      exp_t e;
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      a        = sa;
      b        = sbv;
      op       = sop;
      in_tag   = tg;
      in_valid = 1'b1;
      e.res = use_w ? w : ref_add(sa, sbv, sop);
      e.tag = tg;
      while (!acc) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            sb_q.push_back(e);
         end
         @(posedge clk);
         #1;
         n++;
         if (!acc && n > 2000) begin
            checks++;
            failures++;
            $display("FAIL send_timeout tag=%h", tg);
            break;
         end
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain(string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] hr;
      logic [7:0]  ht;
      int          base;
      logic [31:0] ra, rb;
      logic        ro;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = 1'b0;
      in_tag    = '0;
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_tag", 32'(out_tag), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // latency and tag return
      send(32'h3F800000, 32'h3F800000, 1'b0, 8'hA5, 1'b1, 32'h40000000);
      idle();
      check("lat_0", 32'(out_valid), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("lat_%0d", i), 32'(out_valid), (i == 3) ? 1 : 0);
      end
      check("lat_result", result, 32'h40000000);
      check("lat_tag", 32'(out_tag), 32'hA5);
      drain("drain_lat");

      // directed arithmetic and boundary cases
      send(32'h3FC00000, 32'h3FC00000, 1'b1, 8'h01, 1'b1, 32'h00000000);
      send(32'h4B800000, 32'h3F800000, 1'b0, 8'h02, 1'b1, 32'h4B800000);
      send(32'h7F800000, 32'hFF800000, 1'b0, 8'h03, 1'b1, 32'h7FC00000);
      send(32'h7FC00001, 32'h3F800000, 1'b0, 8'h04, 1'b1, 32'h7FC00000);
      send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 8'h05, 1'b1, 32'h7F800000);
      send(32'h80000000, 32'h80000000, 1'b0, 8'h06, 1'b1, 32'h80000000);
      send(32'h3F800001, 32'h3F800000, 1'b1, 8'h07, 1'b1, 32'h34000000);
      send(32'h00000000, 32'h80000000, 1'b0, 8'h08, 1'b1, 32'h00000000);
      send(32'h00000000, 32'h40400000, 1'b1, 8'h09, 1'b1, 32'hC0400000);
      send(32'h7F800000, 32'h7F800000, 1'b0, 8'h0A, 1'b1, 32'h7F800000);
      send(32'h00800000, 32'h00C00000, 1'b1, 8'h0B, 1'b1, 32'h80000000);
      send(32'h40000000, 32'hBF800000, 1'b0, 8'h0C, 1'b1, 32'h3F800000);
      idle();
      drain("drain_dir");

      // stream of 10 with a 4-cycle output stall
      base = outs_seen;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               ra = rnd_fp(127);
               rb = rnd_fp(127);
               send(ra, rb, 1'($urandom), 8'(8'h20 + i), 1'b0, 32'h0);
            end
            idle();
         end
         begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin
               @(posedge clk);
               #1;
               n++;
            end
            out_ready = 1'b0;
            hr = result;
            ht = out_tag;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               check("stall_in_ready", 32'(in_ready), 32'd0);
               check("stall_result", result, hr);
               check("stall_tag", 32'(out_tag), 32'(ht));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain("drain_stall");
      check("stall_count", 32'(outs_seen - base), 32'd10);

      // reset with three operations in flight
      out_ready = 1'b0;
      send(32'h3F800000, 32'h40000000, 1'b0, 8'h31, 1'b0, 32'h0);
      send(32'h40400000, 32'h3F800000, 1'b1, 8'h32, 1'b0, 32'h0);
      send(32'h41200000, 32'h3F000000, 1'b0, 8'h33, 1'b0, 32'h0);
      idle();
      @(posedge clk);
      #1;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_result", result, 32'd0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      base      = outs_seen;
      repeat (8) @(posedge clk);
      #1;
      check("no_stale_out", 32'(outs_seen - base), 32'd0);

      // random regression with random backpressure and input gaps
      rand_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               int ne;
               ne = int'($urandom_range(1, 254));
               ra = rnd_fp(ne);
               if ($urandom_range(0, 4) == 0)
                  rb = ra ^ 32'($urandom_range(0, 7));
               else
                  rb = rnd_fp(ne);
               ro = 1'($urandom);
               send(ra, rb, ro, 8'(i), 1'b0, 32'h0);
               if ($urandom_range(0, 4) == 0) begin
                  idle();
                  @(posedge clk);
                  #1;
               end
            end
            idle();
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain("drain_rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
- 3-stage pipelined IEEE 754 single-precision adder/subtractor with valid/ready handshake.
- Directly downstream of the float multiplier in the FFT datapath: consumes mul_float products (twiddle terms) and forms butterfly sums/differences.
- Rounding is truncation, consistent with the multiplier. Subnormals are flushed to zero.

Parameters:
- TAG_W, 8, width of the sideband tag carried alongside each operation (butterfly/bin index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts an operation this cycle.
- a  in  32  IEEE 754 operand A.
- b  in  32  IEEE 754 operand B.
- op  in  1  0: a+b, 1: a-b.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  32  IEEE 754 sum/difference.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (async, active-high): all stage valid bits, out_valid, result and out_tag go to 0. In-flight operations are discarded; nothing is emitted for them after rst deasserts.
- Advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - When adv=0 the whole pipe freezes: stage registers, result and out_tag hold.
- Latency: exactly 3 cycles from the accepting edge to out_valid with adv high throughout. Throughput is 1 operation per cycle.
- Bubbles propagate as valid=0 stages and do not block acceptance.
- Operand B sign is inverted when op=1 before any processing.
- Stage 1, unpack/align:
  - Exponent 0 means the operand is zero (mantissa ignored).
  - Swap so |X| >= |Y| (compare {exp, mant}). d = expX - expY.
  - Mantissas become 27 bits: {hidden 1, mant, 3'b000}. Y is shifted right by d; d >= 27 gives 0. Shifted-out bits are discarded (no sticky).
  - Special flags, result sign and expX are registered.
- Stage 2, add:
  - Same signs: 28-bit sum. Different signs: X - Y (non-negative by construction).
- Stage 3, normalize/pack:
  - Carry out (bit 27): shift right 1, exp+1.
  - Otherwise, left-shift until bit 26 is set, decrementing exp by the shift count (leading-zero count 0..26).
  - Mantissa is bits [25:3] after normalization; lower bits are truncated.
- Boundary conditions, in priority order:
  - Either input NaN (exp FF, mant != 0): result 7FC00000.
  - +Inf plus -Inf (after op inversion): 7FC00000.
  - Single Inf, or both Inf with the same sign: that Inf.
  - Both zero: sign = signA & signB' (so -0 + -0 = -0, otherwise +0).
  - One zero: the other operand, after op inversion.
  - Exact cancellation (sum 0): +0 (00000000).
  - Exponent after normalization >= 255: {sign, FF, 0} (Inf).
  - Exponent after normalization <= 0: {sign, 00, 0} (flush to zero).
- Simultaneous in/out transfer with a full pipe is legal and sustains 1 operation per cycle.

Decomposition:
- Package fp32_pkg:
  - Constants FP_NAN=32'h7FC00000, FP_EXP_MAX=8'hFF, FP_BIAS=127, FP_MANT_W=23, FP_EXP_W=8.
  - Field widths shared with the multiplier.
- One sub-module, fp_lzc28: combinational 28-bit leading-zero counter returning a 5-bit count. Used in stage 3 and reusable by future normalizing stages.

Test Plan:
- 3F800000 + 3F800000, op=0, out_ready=1 -> 40000000 with out_valid exactly 3 cycles after acceptance, and out_tag equal to in_tag.
- 3FC00000 - 3FC00000 (op=1) -> 00000000. 4B800000 + 3F800000 -> 4B800000 (the small operand is truncated away).
- Specials:
  - 7F800000 + FF800000 -> 7FC00000.
  - 7FC00001 + 3F800000 -> 7FC00000.
  - 7F7FFFFF + 7F7FFFFF -> 7F800000.
  - 80000000 + 80000000 -> 80000000.
- Back-to-back stream of 10 operations with out_ready held low for 4 cycles once 3 results are in flight:
  - in_ready is 0 and result/out_tag are stable during the stall.
  - All 10 results emerge in order with no loss or duplication.
- Cancellation normalization: 3F800001 - 3F800000 -> 34000000 (exponent drops by 23).
- Assert rst for 1 cycle with 3 operations in flight -> out_valid falls immediately (async), and no stale results are emitted after release.
- Random regression against a reference model implementing the truncation/flush rules above.
